// File: rtl/ts_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : ts_pkg                                                       |
// | Purpose   : Shared MPEG-TS constants, packet-type and reader-state enums |
// |             for the T2-MI to TS encapsulator.                            |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package ts_pkg;

   localparam logic [7:0] TS_LEN     = 8'd188;
   localparam logic [7:0] TS_HDR     = 8'd4;
   localparam logic [7:0] TS_PAY     = TS_LEN - TS_HDR;   // 184
   localparam logic [7:0] TS_SYNC    = 8'h47;
   localparam logic [1:0] AFC_PAY    = 2'b01;
   localparam logic [1:0] AFC_AF_PAY = 2'b11;

   // How a closed bank must be framed on output
   typedef enum logic [1:0] {
      PKT_A = 2'd0,   // 184 payload bytes, no pointer
      PKT_B = 2'd1,   // pointer_field + 183 bytes, PUSI set
      PKT_C = 2'd2    // empty adaptation field + 183 bytes
   } pkt_type_t;

   typedef enum logic [2:0] {
      RD_IDLE = 3'd0,
      RD_HDR  = 3'd1,
      RD_OPT  = 3'd2,
      RD_PAY  = 3'd3,
      RD_REL  = 3'd4
   } rd_state_t;

   // Payload bytes carried after the header/option byte
   function automatic logic [7:0] pay_len(input pkt_type_t t);
      return (t == PKT_A) ? TS_PAY : (TS_PAY - 8'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ts_bank_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : ts_bank_ram                                                  |
// | Purpose   : Two 256x8 payload banks as one simple dual-port RAM; address |
// |             MSB selects the bank. Registered read, 1-cycle latency.     |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module ts_bank_ram (
   input  logic       CLK,
   input  logic       i_we,
   input  logic [8:0] i_waddr,
   input  logic [7:0] i_wdata,
   input  logic [8:0] i_raddr,
   output logic [7:0] o_rdata
);

   logic [7:0] r_mem [0:511];
   logic [7:0] r_q;

   // Write port from the writer, registered read port for the reader
   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/t2mi_ts_encapsulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : t2mi_ts_encapsulator                                         |
// | Purpose   : Packs a T2-MI byte stream into 188-byte MPEG-TS packets on   |
// |             one PID with PUSI/pointer_field, CC and two payload banks.   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module t2mi_ts_encapsulator
   import ts_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  DATA_IN,
   input  logic        ENA_IN,
   input  logic        START_IN,
   input  logic [12:0] PID,
   output logic [7:0]  TS_DATA,
   output logic        TS_VALID,
   output logic        TS_SOP,
   input  logic        TS_READY,
   output logic        OVERFLOW,
   output logic [2:0]  state_mon
);

   // ---------------- bank bookkeeping / writer state ----------------
   logic        r_wbank;
   logic [7:0]  r_count;
   logic        r_start_seen;
   logic [7:0]  r_ptr;
   logic [1:0]  r_full;
   pkt_type_t   r_type [2];
   logic [7:0]  r_bptr [2];
   logic        r_overflow;

   // ---------------- reader state ----------------
   rd_state_t   r_state;
   logic        r_rbank;
   logic [7:0]  r_raddr;
   logic [7:0]  r_idx;
   logic [3:0]  r_cc;
   logic [12:0] r_pid;
   pkt_type_t   r_rtype;
   logic [7:0]  r_rptr;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_sop;

   // ---------------- writer decode ----------------
   logic        w_rel;
   logic        w_cur_busy;
   logic        w_nxt_busy;
   logic        w_accept;
   logic        w_first_start;
   logic        w_type_c;
   logic        w_new_seen;
   logic [7:0]  w_new_ptr;
   logic [7:0]  w_new_count;
   logic        w_close_a;
   logic        w_close_b;
   logic        w_we;
   logic [8:0]  w_waddr;

   // ---------------- reader decode ----------------
   logic        w_free;
   logic        w_load_pay;
   logic [8:0]  w_raddr;
   logic [7:0]  w_rdata;

   // A bank released by the reader this cycle already counts as free
   assign w_rel      = (r_state == RD_REL);
   assign w_cur_busy = r_full[r_wbank]  && !(w_rel && (r_rbank == r_wbank));
   assign w_nxt_busy = r_full[~r_wbank] && !(w_rel && (r_rbank != r_wbank));

   assign w_accept      = ENA_IN && !w_cur_busy;
   assign w_first_start = START_IN && !r_start_seen;
   assign w_type_c      = w_accept && w_first_start && (r_count == (TS_PAY - 8'd1));
   assign w_new_seen    = r_start_seen || START_IN;
   assign w_new_ptr     = w_first_start ? r_count : r_ptr;
   assign w_new_count   = r_count + 8'd1;
   assign w_close_a     = w_accept && !w_type_c && !w_new_seen && (w_new_count == TS_PAY);
   assign w_close_b     = w_accept && !w_type_c &&  w_new_seen && (w_new_count == (TS_PAY - 8'd1));

   // A type-C start byte opens the next bank at address 1 unless that bank is still pending
   assign w_we    = w_accept && !(w_type_c && w_nxt_busy);
   assign w_waddr = w_type_c ? {~r_wbank, 8'd1} : {r_wbank, w_new_count};

   // Output slot can take a new byte when empty or being transferred now
   assign w_free     = !r_valid || TS_READY;
   assign w_load_pay = (r_state == RD_PAY) && w_free;
   // Look one address ahead whenever a payload byte is consumed so the RAM keeps pace
   assign w_raddr    = {r_rbank, (w_load_pay ? (r_raddr + 8'd1) : r_raddr)};

   ts_bank_ram u_ram (
      .CLK     (CLK),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (DATA_IN),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Writer: fill banks, apply close rules, track bank occupancy and overflow
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wbank      <= 1'b0;
         r_count      <= 8'd0;
         r_start_seen <= 1'b0;
         r_ptr        <= 8'd0;
         r_full       <= 2'b00;
         r_type[0]    <= PKT_A;
         r_type[1]    <= PKT_A;
         r_bptr[0]    <= 8'd0;
         r_bptr[1]    <= 8'd0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_rel) begin
            r_full[r_rbank] <= 1'b0;
         end
         if ((ENA_IN && w_cur_busy) || (w_type_c && w_nxt_busy)) begin
            r_overflow <= 1'b1;
         end
         if (w_type_c) begin
            r_full[r_wbank] <= 1'b1;
            r_type[r_wbank] <= PKT_C;
            r_bptr[r_wbank] <= 8'd0;
            r_wbank         <= ~r_wbank;
            r_ptr           <= 8'd0;
            if (w_nxt_busy) begin
               r_count      <= 8'd0;
               r_start_seen <= 1'b0;
            end else begin
               r_count      <= 8'd1;
               r_start_seen <= 1'b1;
            end
         end else if (w_close_a || w_close_b) begin
            r_full[r_wbank] <= 1'b1;
            r_type[r_wbank] <= w_close_a ? PKT_A : PKT_B;
            r_bptr[r_wbank] <= w_close_a ? 8'd0 : w_new_ptr;
            r_wbank         <= ~r_wbank;
            r_count         <= 8'd0;
            r_start_seen    <= 1'b0;
            r_ptr           <= 8'd0;
         end else if (w_accept) begin
            r_count      <= w_new_count;
            r_start_seen <= w_new_seen;
            r_ptr        <= w_new_ptr;
         end
      end
   end

   // Reader FSM: emit header, optional pointer/AF byte and payload with valid/ready hold
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= RD_IDLE;
         r_rbank <= 1'b0;
         r_raddr <= 8'd0;
         r_idx   <= 8'd0;
         r_cc    <= 4'd0;
         r_pid   <= 13'd0;
         r_rtype <= PKT_A;
         r_rptr  <= 8'd0;
         r_data  <= 8'd0;
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
      end else begin
         case (r_state)
            RD_IDLE: begin
               if (w_free) begin
                  if (r_full[r_rbank]) begin
                     r_data  <= TS_SYNC;
                     r_valid <= 1'b1;
                     r_sop   <= 1'b1;
                     r_pid   <= PID;
                     r_rtype <= r_type[r_rbank];
                     r_rptr  <= r_bptr[r_rbank];
                     r_raddr <= 8'd1;
                     r_idx   <= 8'd1;
                     r_state <= RD_HDR;
                  end else begin
                     r_valid <= 1'b0;
                     r_sop   <= 1'b0;
                  end
               end
            end
            RD_HDR: begin
               if (w_free) begin
                  r_sop <= 1'b0;
                  case (r_idx[1:0])
                     2'd1: r_data <= {1'b0, (r_rtype == PKT_B), 1'b0, r_pid[12:8]};
                     2'd2: r_data <= r_pid[7:0];
                     default: r_data <= {2'b00,
                                         ((r_rtype == PKT_C) ? AFC_AF_PAY : AFC_PAY),
                                         r_cc};
                  endcase
                  if (r_idx == 8'd3) begin
                     r_idx   <= 8'd0;
                     r_state <= (r_rtype == PKT_A) ? RD_PAY : RD_OPT;
                  end else begin
                     r_idx <= r_idx + 8'd1;
                  end
               end
            end
            RD_OPT: begin
               if (w_free) begin
                  r_data  <= (r_rtype == PKT_B) ? r_rptr : 8'h00;
                  r_idx   <= 8'd0;
                  r_state <= RD_PAY;
               end
            end
            RD_PAY: begin
               if (w_free) begin
                  r_data  <= w_rdata;
                  r_raddr <= r_raddr + 8'd1;
                  r_idx   <= r_idx + 8'd1;
                  if (r_idx == (pay_len(r_rtype) - 8'd1)) begin
                     r_state <= RD_REL;
                  end
               end
            end
            RD_REL: begin
               // Last byte already sits in the output register, so the bank can go
               r_rbank <= ~r_rbank;
               r_cc    <= r_cc + 4'd1;
               r_state <= RD_IDLE;
               if (w_free) begin
                  r_valid <= 1'b0;
                  r_sop   <= 1'b0;
               end
            end
            default: begin
               r_state <= RD_IDLE;
            end
         endcase
      end
   end

   assign TS_DATA   = r_data;
   assign TS_VALID  = r_valid;
   assign TS_SOP    = r_sop;
   assign OVERFLOW  = r_overflow;
   assign state_mon = r_state;

endmodule
`default_nettype wire

// File: tb/tb_t2mi_ts_encapsulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_t2mi_ts_encapsulator                                      |
// | Purpose   : Directed self-checking bench for t2mi_ts_encapsulator.       |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_t2mi_ts_encapsulator;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  DATA_IN = 8'd0;
   logic        ENA_IN = 1'b0;
   logic        START_IN = 1'b0;
   logic [12:0] PID = 13'h1000;
   logic [7:0]  TS_DATA;
   logic        TS_VALID;
   logic        TS_SOP;
   logic        TS_READY = 1'b1;
   logic        OVERFLOW;
   logic [2:0]  state_mon;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] cap_q [$];
   bit         sop_q [$];
   logic [7:0] s_q   [$];

   t2mi_ts_encapsulator dut (
      .CLK       (CLK),
      .RST       (RST),
      .DATA_IN   (DATA_IN),
      .ENA_IN    (ENA_IN),
      .START_IN  (START_IN),
      .PID       (PID),
      .TS_DATA   (TS_DATA),
      .TS_VALID  (TS_VALID),
      .TS_SOP    (TS_SOP),
      .TS_READY  (TS_READY),
      .OVERFLOW  (OVERFLOW),
      .state_mon (state_mon)
   );

   always #5 CLK = ~CLK;

   // Record every byte that will transfer at the coming rising edge
   always @(negedge CLK) begin
      if (RST && TS_VALID && TS_READY) begin
         cap_q.push_back(TS_DATA);
         sop_q.push_back(TS_SOP);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, observed no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One input byte followed by an idle cycle (input rate below output rate)
   task automatic send_byte(input bit st);
      logic [7:0] v;
      v = 8'(s_q.size() * 7 + 3);
      s_q.push_back(v);
      DATA_IN  = v;
      START_IN = st;
      ENA_IN   = 1'b1;
      step();
      ENA_IN   = 1'b0;
      START_IN = 1'b0;
      step();
   endtask

   task automatic send_pkt(input int n, input bit st);
      for (int i = 0; i < n; i++) begin
         send_byte(st && (i == 0));
      end
   endtask

   task automatic wait_bytes(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while ((cap_q.size() < n) && (k < budget)) begin
         step();
         k++;
      end
      chk({tag, " timeout"}, 32'(cap_q.size() >= n), 32'd1);
   endtask

   task automatic do_reset();
      RST      = 1'b0;
      ENA_IN   = 1'b0;
      START_IN = 1'b0;
      step();
      step();
      RST = 1'b1;
      cap_q.delete();
      sop_q.delete();
      s_q.delete();
      step();
   endtask

   // Check one captured TS packet: header bytes, single SOP, payload against the stream
   task automatic check_pkt(input string tag, input int off, input logic [39:0] hdr,
                            input int hl, input int sb);
      int bad;
      int nsop;
      chk({tag, " size"}, 32'(cap_q.size() >= off + 188), 32'd1);
      if (cap_q.size() >= off + 188) begin
         for (int i = 0; i < hl; i++) begin
            chk($sformatf("%s hdr%0d", tag, i), 32'(cap_q[off + i]), 32'(hdr[39 - 8 * i -: 8]));
         end
         nsop = 0;
         for (int i = 0; i < 188; i++) begin
            nsop += int'(sop_q[off + i]);
         end
         chk({tag, " sop0"}, 32'(sop_q[off]), 32'd1);
         chk({tag, " nsop"}, 32'(nsop), 32'd1);
         bad = -1;
         for (int j = 0; j < 188 - hl; j++) begin
            if ((bad < 0) && (cap_q[off + hl + j] !== s_q[sb + j])) begin
               bad = j;
            end
         end
         chk({tag, " payload first bad idx"}, 32'(bad), 32'hFFFF_FFFF);
      end
   endtask

   initial begin
      // ---------------- reset values ----------------
      step();
      chk("rst TS_DATA", 32'(TS_DATA), 32'h0);
      chk("rst TS_VALID", 32'(TS_VALID), 32'h0);
      chk("rst TS_SOP", 32'(TS_SOP), 32'h0);
      chk("rst OVERFLOW", 32'(OVERFLOW), 32'h0);
      chk("rst state_mon", 32'(state_mon), 32'h0);
      do_reset();

      // ---------------- continuous 200-byte packets ----------------
      send_pkt(200, 1'b1);
      send_pkt(200, 1'b1);
      wait_bytes("t1", 2 * 188, 1000);
      check_pkt("t1 ts1", 0,   {8'h47, 8'h50, 8'h00, 8'h10, 8'h00}, 5, 0);
      check_pkt("t1 ts2", 188, {8'h47, 8'h50, 8'h00, 8'h11, 8'h11}, 5, 183);
      chk("t1 OVERFLOW", 32'(OVERFLOW), 32'h0);

      // ---------------- 367-byte packet then a start ----------------
      do_reset();
      send_pkt(367, 1'b1);
      send_pkt(183, 1'b1);
      wait_bytes("t2", 3 * 188, 1000);
      check_pkt("t2 ts1", 0,   {8'h47, 8'h50, 8'h00, 8'h10, 8'h00}, 5, 0);
      check_pkt("t2 ts2", 188, {8'h47, 8'h10, 8'h00, 8'h11, 8'h00}, 4, 183);
      check_pkt("t2 ts3", 376, {8'h47, 8'h50, 8'h00, 8'h12, 8'h00}, 5, 367);

      // ---------------- 366-byte packet then a start (adaptation field) ----------------
      do_reset();
      send_pkt(366, 1'b1);
      send_pkt(183, 1'b1);
      wait_bytes("t3", 3 * 188, 1000);
      check_pkt("t3 ts1", 0,   {8'h47, 8'h50, 8'h00, 8'h10, 8'h00}, 5, 0);
      check_pkt("t3 ts2", 188, {8'h47, 8'h10, 8'h00, 8'h31, 8'h00}, 5, 183);
      check_pkt("t3 ts3", 376, {8'h47, 8'h50, 8'h00, 8'h12, 8'h00}, 5, 366);

      // ---------------- latency and backpressure ----------------
      do_reset();
      TS_READY = 1'b0;
      send_pkt(184, 1'b0);
      step();
      step();
      chk("t4 latency valid", 32'(TS_VALID), 32'h1);
      chk("t4 latency sop", 32'(TS_SOP), 32'h1);
      chk("t4 latency sync", 32'(TS_DATA), 32'h47);
      TS_READY = 1'b1;
      wait_bytes("t4 pre-stall", 50, 400);
      TS_READY = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("t4 stall data c%0d", i), 32'(TS_DATA), 32'(s_q[46]));
         chk($sformatf("t4 stall valid c%0d", i), 32'(TS_VALID), 32'h1);
      end
      chk("t4 stall state", 32'(state_mon), 32'h3);
      chk("t4 stall count", 32'(cap_q.size()), 32'd50);
      TS_READY = 1'b1;
      wait_bytes("t4", 188, 400);
      check_pkt("t4 ts1", 0, {8'h47, 8'h10, 8'h00, 8'h10, 8'h00}, 4, 0);

      // ---------------- overflow ----------------
      do_reset();
      TS_READY = 1'b0;
      for (int i = 1; i <= 3 * 184; i++) begin
         send_byte(1'b0);
         if (i == 368) chk("t5 OVERFLOW at 368", 32'(OVERFLOW), 32'h0);
         if (i == 369) chk("t5 OVERFLOW at 369", 32'(OVERFLOW), 32'h1);
      end
      TS_READY = 1'b1;
      wait_bytes("t5", 2 * 188, 1000);
      repeat (400) step();
      chk("t5 total bytes", 32'(cap_q.size()), 32'd376);
      chk("t5 OVERFLOW sticky", 32'(OVERFLOW), 32'h1);
      check_pkt("t5 ts1", 0,   {8'h47, 8'h10, 8'h00, 8'h10, 8'h00}, 4, 0);
      check_pkt("t5 ts2", 188, {8'h47, 8'h10, 8'h00, 8'h11, 8'h00}, 4, 184);

      // ---------------- CC wrap ----------------
      do_reset();
      for (int k = 0; k < 17; k++) begin
         send_pkt(184, 1'b0);
      end
      wait_bytes("t6 cc", 17 * 188, 2000);
      for (int k = 0; k < 17; k++) begin
         chk($sformatf("t6 cc pkt%0d", k), 32'(cap_q[188 * k + 3]), 32'(8'h10 + (k & 15)));
      end
      check_pkt("t6 pkt16", 16 * 188, {8'h47, 8'h10, 8'h00, 8'h10, 8'h00}, 4, 16 * 184);

      // ---------------- PID change mid-packet ----------------
      send_pkt(184, 1'b0);
      wait_bytes("t6 pid sync", 17 * 188 + 1, 400);
      PID = 13'h0ABC;
      send_pkt(184, 1'b0);
      wait_bytes("t6 pid", 19 * 188, 1000);
      check_pkt("t6 pkt17", 17 * 188, {8'h47, 8'h10, 8'h00, 8'h11, 8'h00}, 4, 17 * 184);
      check_pkt("t6 pkt18", 18 * 188, {8'h47, 8'h0A, 8'hBC, 8'h12, 8'h00}, 4, 18 * 184);

      // ---------------- reset mid-packet ----------------
      send_pkt(184, 1'b0);
      wait_bytes("t6 mid", 19 * 188 + 100, 1000);
      RST = 1'b0;
      #1;
      chk("t6 mrst TS_DATA", 32'(TS_DATA), 32'h0);
      chk("t6 mrst TS_VALID", 32'(TS_VALID), 32'h0);
      chk("t6 mrst TS_SOP", 32'(TS_SOP), 32'h0);
      chk("t6 mrst OVERFLOW", 32'(OVERFLOW), 32'h0);
      chk("t6 mrst state_mon", 32'(state_mon), 32'h0);
      do_reset();
      send_pkt(184, 1'b0);
      wait_bytes("t6 after rst", 188, 400);
      check_pkt("t6 after rst", 0, {8'h47, 8'h0A, 8'hBC, 8'h10, 8'h00}, 4, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
